// File: rtl/demux_1x64_scan.sv
// Serial-to-lane scan demux: 64 bits on d/v are routed to y[s], y[s+1], ... (mod 64).
// Define DEMUX_PARITY_EN to add a trailing even-parity bit checked against y.
module demux_1x64_scan (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [5:0]  s,
    input  logic        d,
    input  logic        v,
    output logic [63:0] y,
    output logic        busy,
    output logic        done,
    output logic        perr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
`ifdef DEMUX_PARITY_EN
        PARITY = 2'd2,
`endif
        DONE   = 2'd3
    } state_t;

    state_t      state, state_nx;
    logic [5:0]  idx;
    logic [6:0]  count;
`ifdef DEMUX_PARITY_EN
    logic        perr_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (start) state_nx = SHIFT;
            SHIFT: begin
                if (v && count == 7'd63) begin
`ifdef DEMUX_PARITY_EN
                    state_nx = PARITY;
`else
                    state_nx = DONE;
`endif
                end
            end
`ifdef DEMUX_PARITY_EN
            PARITY: if (v) state_nx = DONE;
`endif
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Lane register and scan bookkeeping; y is left untouched after DONE until the next start.
    always_ff @(posedge clk) begin
        if (rst) begin
            y     <= '0;
            idx   <= '0;
            count <= '0;
`ifdef DEMUX_PARITY_EN
            perr_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        y     <= '0;
                        idx   <= s;
                        count <= '0;
`ifdef DEMUX_PARITY_EN
                        perr_q <= 1'b0;
`endif
                    end
                end
                SHIFT: begin
                    if (v) begin
                        y[idx] <= d;
                        idx    <= idx + 6'd1;
                        count  <= count + 7'd1;
                    end
                end
`ifdef DEMUX_PARITY_EN
                PARITY: if (v) perr_q <= d ^ (^y);
`endif
                default: ;
            endcase
        end
    end

    always_comb begin
        busy = (state == SHIFT);
`ifdef DEMUX_PARITY_EN
        if (state == PARITY) busy = 1'b1;
`endif
        done = (state == DONE);
`ifdef DEMUX_PARITY_EN
        perr = done & perr_q;
`else
        perr = 1'b0;
`endif
    end

endmodule

// File: doc/demux_1x64_scan.md
DEMUX_1X64_SCAN -- requirements
Module: demux_1x64_scan

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock; the only clock.
REQ-002 SHALL have port: rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 SHALL have port: start  input  1  begin a 64-bit scan; honoured only in IDLE.
REQ-004 SHALL have port: s  input  6  start lane index, captured when start is accepted.
REQ-005 SHALL have port: d  input  1  serial data bit.
REQ-006 SHALL have port: v  input  1  d qualifier; one bit accepted per clk with v=1 in SHIFT (or PARITY).
REQ-007 SHALL have port: y  output  64  lane register; bit k holds the bit routed to lane k.
REQ-008 SHALL have port: busy  output  1  high in SHIFT and PARITY states.
REQ-009 SHALL have port: done  output  1  one-cycle pulse on scan completion.
REQ-010 SHALL have port: perr  output  1  parity error flag, valid while done=1.

Function
REQ-011 SHALL implement FSM states IDLE, SHIFT, PARITY (macro only), DONE.
REQ-012 SHALL, in IDLE with start=1: clear y to 0, load idx=s, clear count, enter SHIFT next edge.
REQ-013 SHALL, in SHIFT with v=1: write y[idx]=d, idx=idx+1 modulo 64 (63 wraps to 0), count+1.
REQ-014 SHALL hold y, idx, count unchanged in SHIFT/PARITY while v=0 (stall, no timeout).
REQ-015 SHALL leave SHIFT after the 64th accepted bit: to PARITY if DEMUX_PARITY_EN, else DONE.
REQ-016 SHALL assert done=1 for exactly the one cycle spent in DONE, then return to IDLE.
REQ-017 SHALL ignore start outside IDLE; start and v in the same IDLE cycle: start taken, d discarded.
REQ-018 SHALL keep y stable from DONE until the next accepted start; lanes update live during SHIFT.
REQ-019 SHALL have minimum latency start-to-done of 66 cycles with v=1 throughout (67 with parity).
REQ-020 SHALL drive perr=0 whenever done=0.

Reset
REQ-021 SHALL on rst=1 force state IDLE, y=64'h0, idx=0, count=0, busy=0, done=0, perr=0.
REQ-022 SHALL give rst priority over start, v, and any state, including mid-scan; partial y is discarded.

Configuration
REQ-023 SHALL use macro DEMUX_PARITY_EN to compile in parity checking.
REQ-024 SHALL, with DEMUX_PARITY_EN defined: in PARITY, the next v=1 bit is compared to XOR of y; perr=1 in DONE on mismatch (even parity).
REQ-025 SHALL, without DEMUX_PARITY_EN: omit PARITY state, tie perr to 0.

Verification
REQ-026 SHALL test: rst, start with s=0, 64 bits d=0,1,0,1... v=1 -> y=64'hAAAA_AAAA_AAAA_AAAA, done pulse at cycle 66, busy low after.
REQ-027 SHALL test: start with s=6'd60, first bit 1 then 63 zeros -> y=64'h1000_0000_0000_0000 (wrap 63->0 exercised).
REQ-028 SHALL test: s=0, all ones, v toggling 1/0 every cycle -> y=64'hFFFF_FFFF_FFFF_FFFF, done 64 cycles later than unstalled run.
REQ-029 SHALL test: rst asserted after 20 bits -> next cycle y=0, busy=0; start asserted during SHIFT ignored.
REQ-030 SHALL test (DEMUX_PARITY_EN): y=64'h1 then parity bit 1 -> perr=0; repeat with parity bit 0 -> perr=1 with done.
